mult_seq_ctrl: RTL and testbench

Sequencer for the team's 7-bit serial shift-add multiplier datapath, which consumes one multiplier bit per clock and is controlled by start/done.
- Accepts operand pairs over a valid/ready request channel.
- Drives the datapath's serial bit, parallel operand, start and done inputs for exactly WIDTH accumulate cycles.
- Captures the 2*WIDTH product before the datapath's done-clear takes effect.
- Returns the product over a valid/ready response channel.

---
 rtl/mult_ctrl_pkg.sv | 15 +
 rtl/mult_seq_ctrl.sv | 108 ++++++++++
 tb/tb_mult_seq_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_ctrl_pkg.sv
// Shared types and sizing for the serial multiplier sequencer.
// Zero-operand fast path is enabled by defining MULT_ZERO_SKIP_EN.
package mult_ctrl_pkg;

  localparam int MULT_WIDTH = 7;
  localparam int MULT_CNT_W = $clog2(MULT_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    RESP
  } state_e;

endpackage

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the serial shift-add multiplier datapath.
// Optional zero-operand bypass: define MULT_ZERO_SKIP_EN.
module mult_seq_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [2*WIDTH-1:0] resp_prod,
  output logic               dp_a,
  output logic [WIDTH-1:0]   dp_b,
  output logic               dp_start,
  output logic               dp_done,
  input  logic [2*WIDTH-1:0] dp_out
);

  state_e state_q;
  state_e state_d;

  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_q;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod_q;

  logic accept;
  logic skip;
  logic last;

  assign accept = req_valid && req_ready;
  assign last   = (cnt == CNT_W'(WIDTH - 1));

`ifdef MULT_ZERO_SKIP_EN
  assign skip = (req_a == '0) || (req_b == '0);
`else
  assign skip = 1'b0;
`endif

  assign dp_b      = b_q;
  assign resp_prod = prod_q;

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    dp_start   = 1'b0;
    dp_done    = 1'b0;
    dp_a       = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        dp_start  = 1'b1;
        if (accept) state_d = skip ? RESP : RUN;
      end
      RUN: begin
        dp_a = a_sh[0];
        if (last) state_d = DONE;
      end
      DONE: begin
        dp_done = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        dp_start   = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh    <= '0;
      b_q     <= '0;
      cnt     <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            a_sh <= req_a;
            b_q  <= req_b;
            cnt  <= '0;
            if (skip) prod_q <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          cnt  <= cnt + 1'b1;
        end
        // dp_out still holds the product here; the datapath clears after this edge
        DONE: prod_q <= dp_out;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl with a behavioural serial datapath.
// Build with MULT_ZERO_SKIP_EN to match the zero-bypass RTL.
module tb_mult_seq_ctrl;

  localparam int W = 7;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid;
  logic           req_ready;
  logic [W-1:0]   req_a;
  logic [W-1:0]   req_b;
  logic           resp_valid;
  logic           resp_ready;
  logic [2*W-1:0] resp_prod;
  logic           dp_a;
  logic [W-1:0]   dp_b;
  logic           dp_start;
  logic           dp_done;
  logic [2*W-1:0] dp_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_prod  (resp_prod),
    .dp_a       (dp_a),
    .dp_b       (dp_b),
    .dp_start   (dp_start),
    .dp_done    (dp_done),
    .dp_out     (dp_out)
  );

  // shift-add datapath: P = (P + bit*b*2^W) / 2 each cycle
  logic [2*W:0] p_sum;
  always_comb begin
    p_sum = {1'b0, dp_out};
    if (dp_a) p_sum = p_sum + {1'b0, dp_b, {W{1'b0}}};
  end

  always @(posedge clk) begin
    if (dp_start || dp_done) dp_out <= '0;
    else                     dp_out <= p_sum[2*W:1];
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      assert (!(dp_start === 1'b1 && dp_done === 1'b1)) else begin
        errors++;
        $error("FAIL start_done_excl observed=%0b%0b required=not both",
               dp_start, dp_done);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_skip(input int a, input int b);
`ifdef MULT_ZERO_SKIP_EN
    return (a == 0) || (b == 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic run_op(input int a, input int b, input int stall);
    int n;
    int lat;
    int exp_p;
    bit sk;
    exp_p = a * b;
    sk    = is_skip(a, b);
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("req_ready_wait", {31'd0, req_ready}, 1);
    req_valid = 1'b1;
    req_a     = W'(a);
    req_b     = W'(b);
    step();
    req_valid = 1'b0;
    req_a     = W'($urandom);
    req_b     = W'($urandom);
    lat = 0;
    if (!sk) begin
      for (int i = 0; i < W; i++) begin
        chk("run_dp_a", {31'd0, dp_a}, (a >> i) & 1);
        chk("run_dp_b", {25'd0, dp_b}, b);
        chk("run_start", {31'd0, dp_start}, 0);
        chk("run_ready", {31'd0, req_ready}, 0);
        req_a = W'($urandom);
        step();
        lat++;
      end
      chk("done_flag", {31'd0, dp_done}, 1);
      chk("done_dp_a", {31'd0, dp_a}, 0);
    end else begin
      chk("skip_start", {31'd0, dp_start}, 1);
    end
    while (resp_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    chk("latency", lat, sk ? 0 : W + 1);
    for (int s = 0; s < stall; s++) begin
      chk("stall_valid", {31'd0, resp_valid}, 1);
      chk("stall_prod", {18'd0, resp_prod}, exp_p);
      chk("stall_ready", {31'd0, req_ready}, 0);
      chk("stall_start", {31'd0, dp_start}, 1);
      step();
    end
    chk("resp_valid", {31'd0, resp_valid}, 1);
    chk("resp_prod", {18'd0, resp_prod}, exp_p);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("resp_drop", {31'd0, resp_valid}, 0);
  endtask

  initial begin
    int ra;
    int rb;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    step();
    step();
    chk("rst_req_ready", {31'd0, req_ready}, 1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 0);
    chk("rst_resp_prod", {18'd0, resp_prod}, 0);
    chk("rst_dp_start", {31'd0, dp_start}, 1);
    chk("rst_dp_done", {31'd0, dp_done}, 0);
    chk("rst_dp_a", {31'd0, dp_a}, 0);
    chk("rst_dp_b", {25'd0, dp_b}, 0);
    rst_n = 1'b1;
    step();

    run_op(5, 3, 0);
    run_op(127, 127, 0);
    run_op(1, 127, 0);
    run_op(64, 2, 0);
    run_op(9, 7, 5);

    // abort mid-run after three accumulate edges
    req_valid = 1'b1;
    req_a     = 7'd100;
    req_b     = 7'd50;
    step();
    req_valid = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_ready", {31'd0, req_ready}, 1);
    chk("abort_start", {31'd0, dp_start}, 1);
    chk("abort_prod", {18'd0, resp_prod}, 0);
    for (int i = 0; i < 12; i++) begin
      chk("abort_no_resp", {31'd0, resp_valid}, 0);
      step();
    end
    run_op(2, 6, 0);

    run_op(0, 77, 1);
    run_op(3, 4, 0);
    run_op(10, 11, 0);

    for (int k = 0; k < 25; k++) begin
      ra = int'($urandom_range(0, 127));
      rb = int'($urandom_range(0, 127));
      if (k % 8 == 3) ra = 0;
      if (k % 8 == 6) rb = 0;
      run_op(ra, rb, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
